// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: serialises operand fetches and buffered
// writebacks onto one mutually exclusive READ/WRITE pair, with RAW bypass.
module rf_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WB_DEPTH   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic                  rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);
    localparam int CW = $clog2(WB_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WB_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    state_t                state_r, state_n_s;
    logic [ADDR_WIDTH-1:0] buf_addr_r [WB_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_addr_n_s [WB_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_r [WB_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_n_s [WB_DEPTH];
    logic [CW-1:0]         cnt_r, cnt_pop_s, cnt_n_s;
    logic                  pending_r, pending_n_s, pend_any_s;
    logic [ADDR_WIDTH-1:0] ra1_r, ra2_r, ra1_n_s, ra2_n_s;
    logic                  byp1_r, byp2_r, hit1_s, hit2_s;
    logic [DATA_WIDTH-1:0] bv1_r, bv2_r, val1_s, val2_s;
    logic                  rd_acc_s, wb_acc_s, wb_zero_s, push_s, pop_s;

    // Youngest matching write wins: buffered entries oldest-first, then the same-cycle push.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [ADDR_WIDTH-1:0] ba [WB_DEPTH],
        input logic [DATA_WIDTH-1:0] bd [WB_DEPTH],
        input logic [CW-1:0]         cnt,
        input logic                  push,
        input logic [ADDR_WIDTH-1:0] paddr,
        input logic [DATA_WIDTH-1:0] pdata
    );
        logic                  hit;
        logic [DATA_WIDTH-1:0] val;
        hit = 1'b0;
        val = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < WB_DEPTH; i++) begin
            hit = ((CW'(i) < cnt) && (ba[i] == addr)) ? 1'b1  : hit;
            val = ((CW'(i) < cnt) && (ba[i] == addr)) ? bd[i] : val;
        end
        hit = (push && (paddr == addr)) ? 1'b1  : hit;
        val = (push && (paddr == addr)) ? pdata : val;
        if ((ZERO_REG != 0) && (addr == {ADDR_WIDTH{1'b0}})) begin
            hit = 1'b1;
            val = {DATA_WIDTH{1'b0}};
        end else begin
            hit = hit;
        end
        return {hit, val};
    endfunction

    assign rd_acc_s  = rd_req_valid & rd_req_ready;
    assign wb_acc_s  = wb_valid & wb_ready;
    assign wb_zero_s = (ZERO_REG != 0) && (wb_addr == {ADDR_WIDTH{1'b0}});
    assign push_s    = wb_acc_s & ~wb_zero_s;
    assign pop_s     = (state_r == WR);

    // Post-edge buffer image: a pop shifts entries down, a push lands behind the survivors.
    always_comb begin
        cnt_pop_s = pop_s ? (cnt_r - CW'(1)) : cnt_r;
        for (int i = 0; i < WB_DEPTH - 1; i++) begin
            buf_addr_n_s[i] = pop_s ? buf_addr_r[i + 1] : buf_addr_r[i];
            buf_data_n_s[i] = pop_s ? buf_data_r[i + 1] : buf_data_r[i];
        end
        buf_addr_n_s[WB_DEPTH-1] = buf_addr_r[WB_DEPTH-1];
        buf_data_n_s[WB_DEPTH-1] = buf_data_r[WB_DEPTH-1];
        for (int i = 0; i < WB_DEPTH; i++) begin
            buf_addr_n_s[i] = (push_s && (cnt_pop_s == CW'(i))) ? wb_addr : buf_addr_n_s[i];
            buf_data_n_s[i] = (push_s && (cnt_pop_s == CW'(i))) ? wb_data : buf_data_n_s[i];
        end
        cnt_n_s = cnt_pop_s + (push_s ? CW'(1) : CW'(0));
    end

    // Forwarding snapshot for both operands of a read being accepted this cycle.
    always_comb begin
        {hit1_s, val1_s} = fwd_lookup(rd_addr1, buf_addr_r, buf_data_r, cnt_r, push_s, wb_addr, wb_data);
        {hit2_s, val2_s} = fwd_lookup(rd_addr2, buf_addr_r, buf_data_r, cnt_r, push_s, wb_addr, wb_data);
    end

    // Next-state arbitration: a full buffer must drain before a pending read is served.
    always_comb begin
        pend_any_s = pending_r | rd_acc_s;
        if (cnt_n_s == FULL_CNT) begin
            state_n_s = WR;
        end else if (pend_any_s) begin
            state_n_s = RD;
        end else if (cnt_n_s != CW'(0)) begin
            state_n_s = WR;
        end else begin
            state_n_s = IDLE;
        end
        pending_n_s = pend_any_s & (state_n_s != RD);
        ra1_n_s     = rd_acc_s ? rd_addr1 : ra1_r;
        ra2_n_s     = rd_acc_s ? rd_addr2 : ra2_r;
    end

    // Sequencer state, write buffer, read snapshot and all registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= IDLE;
            cnt_r        <= CW'(0);
            pending_r    <= 1'b0;
            ra1_r        <= {ADDR_WIDTH{1'b0}};
            ra2_r        <= {ADDR_WIDTH{1'b0}};
            byp1_r       <= 1'b0;
            byp2_r       <= 1'b0;
            bv1_r        <= {DATA_WIDTH{1'b0}};
            bv2_r        <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < WB_DEPTH; i++) begin
                buf_addr_r[i] <= {ADDR_WIDTH{1'b0}};
                buf_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
            RF_READ      <= 1'b0;
            RF_WRITE     <= 1'b0;
            RF_ADDR_R1   <= {ADDR_WIDTH{1'b0}};
            RF_ADDR_R2   <= {ADDR_WIDTH{1'b0}};
            RF_ADDR_W    <= {ADDR_WIDTH{1'b0}};
            RF_DATA_W    <= {DATA_WIDTH{1'b0}};
            rd_rsp_valid <= 1'b0;
            rd_data1     <= {DATA_WIDTH{1'b0}};
            rd_data2     <= {DATA_WIDTH{1'b0}};
            wb_ready     <= 1'b0;
            rd_req_ready <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
            pending_r    <= pending_n_s;
            buf_addr_r   <= buf_addr_n_s;
            buf_data_r   <= buf_data_n_s;
            ra1_r        <= ra1_n_s;
            ra2_r        <= ra2_n_s;
            byp1_r       <= rd_acc_s ? hit1_s : byp1_r;
            byp2_r       <= rd_acc_s ? hit2_s : byp2_r;
            bv1_r        <= rd_acc_s ? val1_s : bv1_r;
            bv2_r        <= rd_acc_s ? val2_s : bv2_r;
            RF_READ      <= (state_n_s == RD);
            RF_WRITE     <= (state_n_s == WR);
            RF_ADDR_R1   <= (state_n_s == RD) ? ra1_n_s : RF_ADDR_R1;
            RF_ADDR_R2   <= (state_n_s == RD) ? ra2_n_s : RF_ADDR_R2;
            RF_ADDR_W    <= (state_n_s == WR) ? buf_addr_n_s[0] : RF_ADDR_W;
            RF_DATA_W    <= (state_n_s == WR) ? buf_data_n_s[0] : RF_DATA_W;
            rd_rsp_valid <= (state_r == RD);
            rd_data1     <= (state_r == RD) ? (byp1_r ? bv1_r : RF_DATA_R1) : rd_data1;
            rd_data2     <= (state_r == RD) ? (byp2_r ? bv2_r : RF_DATA_R2) : rd_data2;
            wb_ready     <= (cnt_n_s < FULL_CNT);
            rd_req_ready <= ~pending_n_s & (state_n_s != RD);
        end
    end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Randomised bench for rf_access_ctrl: a register-file memory model plus an
// architectural reference (program-order register values and a write queue).
module tb_rf_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          rd_req_valid, rd_req_ready, rd_rsp_valid;
    logic [AW-1:0] rd_addr1, rd_addr2, wb_addr;
    logic [DW-1:0] rd_data1, rd_data2, wb_data;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [DW-1:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
    logic          RF_READ, RF_WRITE;

    rf_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WB_DEPTH(D), .ZERO_REG(1)) dut (
        .CLK(CLK), .RST(RST),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_rsp_valid(rd_rsp_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
        .RF_DATA_W(RF_DATA_W), .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
    );

    always #5 CLK = ~CLK;

    // Register file: combinational read while READ is high, write at the end of a WRITE cycle.
    logic [DW-1:0] rf_mem  [32];
    logic [DW-1:0] rf_seed [32];
    bit            rf_loaded = 1'b0;
    always @(posedge CLK) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= rf_seed[i];
        end else if (RF_WRITE) begin
            rf_mem[RF_ADDR_W] <= RF_DATA_W;
        end
    end
    assign RF_DATA_R1 = RF_READ ? rf_mem[RF_ADDR_R1] : 'z;
    assign RF_DATA_R2 = RF_READ ? rf_mem[RF_ADDR_R2] : 'z;

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    wr_t           wq[$];
    logic [DW-1:0] arch [32];
    int            m_op;
    bit            m_pend, m_wbr, m_rdr, m_rsp, m_racc, m_wacc;
    logic [AW-1:0] m_a1, m_a2;
    logic [DW-1:0] m_e1, m_e2, m_o1, m_o2;
    int            n_total = 0;
    int            n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        m_op = 0; m_pend = 1'b0; m_wbr = 1'b0; m_rdr = 1'b0; m_rsp = 1'b0;
        m_racc = 1'b0; m_wacc = 1'b0;
        m_o1 = 32'd0; m_o2 = 32'd0;
        for (int i = 0; i < 32; i++) arch[i] = rf_mem[i];
    endtask

    // m_op: 0 nothing, 1 register-file read, 2 register-file write of wq[0].
    task automatic model_step();
        m_wacc = wb_valid && m_wbr;
        m_racc = rd_req_valid && m_rdr;
        m_rsp  = (m_op == 1);
        if (m_op == 1) begin m_o1 = m_e1; m_o2 = m_e2; end
        if (m_op == 2) void'(wq.pop_front());
        if (m_wacc && wb_addr != 5'd0) begin
            arch[wb_addr] = wb_data;
            wq.push_back('{a: wb_addr, d: wb_data});
        end
        if (m_racc) begin
            m_pend = 1'b1; m_a1 = rd_addr1; m_a2 = rd_addr2;
            m_e1 = arch[rd_addr1]; m_e2 = arch[rd_addr2];
        end
        if (wq.size() == D)      m_op = 2;
        else if (m_pend) begin   m_op = 1; m_pend = 1'b0; end
        else if (wq.size() > 0)  m_op = 2;
        else                     m_op = 0;
        m_wbr = (wq.size() < D);
        m_rdr = !m_pend && (m_op != 1);
    endtask

    task automatic check_outputs();
        chk("rf_read", RF_READ, m_op == 1);
        chk("rf_write", RF_WRITE, m_op == 2);
        chk("rw_exclusive", RF_READ & RF_WRITE, 1'b0);
        if (m_op == 1) begin
            chk("rf_addr_r1", RF_ADDR_R1, m_a1);
            chk("rf_addr_r2", RF_ADDR_R2, m_a2);
        end
        if (m_op == 2) begin
            chk("rf_addr_w", RF_ADDR_W, wq[0].a);
            chk("rf_data_w", RF_DATA_W, wq[0].d);
        end
        chk("rsp_valid", rd_rsp_valid, m_rsp);
        chk("rd_data1", rd_data1, m_o1);
        chk("rd_data2", rd_data2, m_o2);
        chk("wb_ready", wb_ready, m_wbr);
        chk("rd_req_ready", rd_req_ready, m_rdr);
    endtask

    task automatic step(input bit rv, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        rd_req_valid = rv; rd_addr1 = a1; rd_addr2 = a2;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wbw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        do begin
            step(1'b0, 5'd0, 5'd0, 1'b1, a, d);
            t++;
        end while (!m_wacc && t < 20);
        chk("wb_accept", m_wacc, 1'b1);
    endtask

    // exp_lat counts edges from the accept edge to the first edge showing rd_rsp_valid.
    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input bit wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input int exp_lat);
        int t = 0;
        int lat = 0;
        do begin
            step(1'b1, a1, a2, (t == 0) ? wv : 1'b0, wa, wd);
            t++;
        end while (!m_racc && t < 20);
        chk("rd_accept", m_racc, 1'b1);
        do begin
            idle(1);
            lat++;
        end while (!rd_rsp_valid && lat < 10);
        chk("rd_latency", lat, exp_lat);
    endtask

    task automatic do_reset(input int n);
        rd_req_valid = 1'b0; wb_valid = 1'b0;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check_outputs();
            chk("rst_addrs", {RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W}, 32'd0);
            chk("rst_wdata", RF_DATA_W, 32'd0);
        end
        model_reset();
        RST = 1'b1;
    endtask

    initial begin
        rd_req_valid = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        for (int i = 0; i < 32; i++) rf_seed[i] = $urandom();
        rf_seed[0]  = 32'd0;
        rf_seed[7]  = 32'h0BAD_0007;
        rf_seed[10] = 32'h5EED_000A;

        do_reset(3);
        rf_loaded = 1'b1;
        idle(1);
        chk("post_rst_wb_ready", wb_ready, 1'b1);
        chk("post_rst_rd_ready", rd_req_ready, 1'b1);

        // basic write then read
        wbw(5'd5, 32'hDEAD_BEEF);
        idle(3);
        rd(5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1);
        chk("basic_d1", rd_data1, 32'hDEAD_BEEF);
        chk("basic_d2", rd_data2, 32'd0);
        idle(2);

        // same-cycle write and read of r7: bypass while RF still holds the old value
        rd(5'd7, 5'd7, 1'b1, 5'd7, 32'h0000_1234, 1);
        chk("raw_d1", rd_data1, 32'h0000_1234);
        chk("raw_d2", rd_data2, 32'h0000_1234);
        chk("raw_rf_old", rf_mem[7], 32'h0BAD_0007);
        idle(3);
        chk("raw_rf_new", rf_mem[7], 32'h0000_1234);

        // fill the buffer while a read holds the port
        step(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'd1);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'd2);
        chk("full_wb_ready", wb_ready, 1'b0);
        wbw(5'd3, 32'd3);
        idle(4);
        chk("drain_r1", rf_mem[1], 32'd1);
        chk("drain_r2", rf_mem[2], 32'd2);
        chk("drain_r3", rf_mem[3], 32'd3);

        // zero register
        wbw(5'd0, 32'hFFFF_FFFF);
        chk("zero_no_write", RF_WRITE, 1'b0);
        rd(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1);
        chk("zero_read", rd_data1 | rd_data2, 32'd0);
        idle(2);

        // reset with a buffered write and a read in flight
        step(1'b1, 5'd9, 5'd10, 1'b1, 5'd9, 32'h99);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 32'hA0);
        step(1'b1, 5'd9, 5'd10, 1'b0, 5'd0, 32'd0);
        do_reset(2);
        idle(4);
        rd(5'd9, 5'd10, 1'b0, 5'd0, 32'd0, 1);
        chk("rst_keep_r9", rd_data1, 32'h99);
        chk("rst_drop_r10", rd_data2, 32'h5EED_000A);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
        end
        idle(8);
        for (int i = 0; i < 32; i++) chk($sformatf("rf_final_%0d", i), rf_mem[i], arch[i]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
